// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port Mem arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the port that did not win last goes next.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req_cpu,
  input  logic req_ldr,
  input  logic last_grant,
  output logic winner,
  output logic valid
);

  always_comb begin
    valid  = req_cpu | req_ldr;
    winner = REQ_CPU;
    if (req_cpu && req_ldr) begin
      winner = ~last_grant;
    end else if (req_ldr) begin
      winner = REQ_LDR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a 1-cycle-latency single-port Mem between the CPU and the loader via a fixed 4-state transaction.
// Define MEM_ARB_WRITE_PROTECT_EN to reject CPU writes below PROT_LIMIT (acked with cpu_err).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter int unsigned       DATA_W     = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] PROT_LIMIT = ADDR_W'(8'h40)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wren,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_wren,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              grant_id
);

`ifdef MEM_ARB_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_id_q, grant_id_d;
  logic              is_wr_q, is_wr_d;
  logic              err_pend_q, err_pend_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ldr_ack_q, ldr_ack_d;
  logic              cpu_err_q, cpu_err_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  logic              pick_winner;
  logic              pick_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_wren;
  logic              wr_blocked;

  rr_pick2 u_pick (
    .req_cpu    (cpu_req),
    .req_ldr    (ldr_req),
    .last_grant (last_grant_q),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  // Winner's command and the write-protect decision, only consumed in IDLE.
  always_comb begin
    sel_addr   = (pick_winner == REQ_LDR) ? ldr_addr  : cpu_addr;
    sel_wdata  = (pick_winner == REQ_LDR) ? ldr_wdata : cpu_wdata;
    sel_wren   = (pick_winner == REQ_LDR) ? ldr_wren  : cpu_wren;
    wr_blocked = WP_EN && (pick_winner == REQ_CPU) && cpu_wren && (cpu_addr < PROT_LIMIT);
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    is_wr_d       = is_wr_q;
    err_pend_d    = err_pend_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = mem_wren_q;
    cpu_rdata_d   = cpu_rdata_q;
    ldr_rdata_d   = ldr_rdata_q;
    cpu_ack_d     = 1'b0;
    ldr_ack_d     = 1'b0;
    cpu_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        mem_wren_d = 1'b0;
        if (pick_valid) begin
          mem_address_d = sel_addr;
          mem_data_d    = sel_wdata;
          mem_wren_d    = sel_wren & ~wr_blocked;
          is_wr_d       = sel_wren;
          err_pend_d    = wr_blocked;
          grant_id_d    = pick_winner;
          last_grant_d  = pick_winner;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        // Mem took the write at the edge closing ISSUE; the pulse is one cycle wide.
        mem_wren_d = 1'b0;
        state_d    = DATA;
      end
      DATA: begin
        if (!is_wr_q) begin
          if (grant_id_q == REQ_LDR) ldr_rdata_d = mem_q;
          else                       cpu_rdata_d = mem_q;
        end
        cpu_ack_d = (grant_id_q == REQ_CPU);
        ldr_ack_d = (grant_id_q == REQ_LDR);
        cpu_err_d = (grant_id_q == REQ_CPU) && err_pend_q;
        state_d   = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        mem_wren_d = 1'b0;
        state_d    = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= REQ_LDR;
      grant_id_q    <= 1'b0;
      is_wr_q       <= 1'b0;
      err_pend_q    <= 1'b0;
      busy_q        <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      cpu_ack_q     <= 1'b0;
      ldr_ack_q     <= 1'b0;
      cpu_err_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      ldr_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      is_wr_q       <= is_wr_d;
      err_pend_q    <= err_pend_d;
      busy_q        <= busy_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      cpu_ack_q     <= cpu_ack_d;
      ldr_ack_q     <= ldr_ack_d;
      cpu_err_q     <= cpu_err_d;
      cpu_rdata_q   <= cpu_rdata_d;
      ldr_rdata_q   <= ldr_rdata_d;
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_err     = cpu_err_q;
  assign ldr_ack     = ldr_ack_q;
  assign ldr_rdata   = ldr_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 1-cycle-latency Mem model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_wren = 1'b0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        ldr_req = 1'b0;
  logic [7:0]  ldr_addr = '0;
  logic [31:0] ldr_wdata = '0;
  logic        ldr_wren = 1'b0;
  logic        ldr_ack;
  logic [31:0] ldr_rdata;
  logic [7:0]  mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q = '0;
  logic        busy;
  logic        grant_id;

  logic [31:0] mem [256];

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        grant;
    int          cyc;
  } exp_t;

  exp_t cpu_q[$];
  exp_t ldr_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wren_cnt = 0;
  int busy_low_cnt = 0;
  int snap;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wren    (cpu_wren),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .cpu_err     (cpu_err),
    .ldr_req     (ldr_req),
    .ldr_addr    (ldr_addr),
    .ldr_wdata   (ldr_wdata),
    .ldr_wren    (ldr_wren),
    .ldr_ack     (ldr_ack),
    .ldr_rdata   (ldr_rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mem model: write and registered read at the same edge.
  always @(posedge clk) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and checks data, err, owner and timing.
  always @(negedge clk) begin
    if (mem_wren) wren_cnt++;
    if (!busy) busy_low_cnt++;
    if (cpu_ack) begin
      if (cpu_q.size() == 0) begin
        chk("cpu_ack_unexpected", 32'(cpu_ack), 32'd0);
      end else begin
        mon_e = cpu_q.pop_front();
        chk("cpu_rdata", cpu_rdata, mon_e.data);
        chk("cpu_err", 32'(cpu_err), 32'(mon_e.err));
        chk("cpu_grant_id", 32'(grant_id), 32'(mon_e.grant));
        chk("cpu_ack_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
    if (ldr_ack) begin
      if (ldr_q.size() == 0) begin
        chk("ldr_ack_unexpected", 32'(ldr_ack), 32'd0);
      end else begin
        mon_e = ldr_q.pop_front();
        chk("ldr_rdata", ldr_rdata, mon_e.data);
        chk("ldr_err_free", 32'(cpu_ack & cpu_err), 32'd0);
        chk("ldr_grant_id", 32'(grant_id), 32'(mon_e.grant));
        chk("ldr_ack_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Issue one transaction from the current negedge; lat is the hand-computed cycle offset of its ack.
  task automatic txn(input logic port, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic wren, input logic [31:0] exp_data, input logic exp_err,
                     input int lat);
    exp_t e;
    int   n;
    logic got;
    e.data  = exp_data;
    e.err   = exp_err;
    e.grant = port;
    e.cyc   = cyc + lat;
    if (port) begin
      ldr_q.push_back(e);
      ldr_addr = addr; ldr_wdata = wdata; ldr_wren = wren; ldr_req = 1'b1;
    end else begin
      cpu_q.push_back(e);
      cpu_addr = addr; cpu_wdata = wdata; cpu_wren = wren; cpu_req = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      got = port ? ldr_ack : cpu_ack;
    end while (!got && n < 40);
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_ack_timeout: got no ack expected ack within 40 cycles", port ? "ldr" : "cpu");
    end
    if (port) begin ldr_req = 1'b0; ldr_wren = 1'b0; end
    else      begin cpu_req = 1'b0; cpu_wren = 1'b0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    mem[8'h05] <= 32'hDEADBEEF;
    mem[8'h11] <= 32'hA5A50011;
    mem[8'h20] <= 32'h0BAD0020;
    mem[8'h3F] <= 32'h1111003F;
    mem[8'h40] <= 32'h22220040;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant_id", 32'(grant_id), 32'd0);
    chk("reset_mem_wren", 32'(mem_wren), 32'd0);
    chk("reset_cpu_rdata", cpu_rdata, 32'd0);

    // CPU read of preloaded word.
    txn(1'b0, 8'h05, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 3);
    @(negedge clk);

    // Loader write, then CPU reads it back.
    wren_cnt = 0;
    txn(1'b1, 8'h10, 32'h12345678, 1'b1, 32'h0, 1'b0, 3);
    chk("ldr_write_pulse_width", 32'(wren_cnt), 32'd1);
    @(negedge clk);
    txn(1'b0, 8'h10, 32'h0, 1'b0, 32'h12345678, 1'b0, 3);
    @(negedge clk);

    // Reset during ISSUE of a loader write.
    ldr_addr = 8'h20; ldr_wdata = 32'hFFFF0020; ldr_wren = 1'b1; ldr_req = 1'b1;
    @(negedge clk);
    chk("issue_mem_wren", 32'(mem_wren), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mem_wren_drop", 32'(mem_wren), 32'd0);
    chk("rst_busy_drop", 32'(busy), 32'd0);
    ldr_req = 1'b0; ldr_wren = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_grant_id", 32'(grant_id), 32'd0);
    chk("post_rst_ldr_rdata", ldr_rdata, 32'd0);
    chk("abandoned_write_mem", mem[8'h20], 32'h0BAD0020);

    // Simultaneous requests: CPU, loader, CPU.
    fork
      begin
        txn(1'b0, 8'h05, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 3);
        txn(1'b0, 8'h11, 32'h0, 1'b0, 32'hA5A50011, 1'b0, 8);
      end
      txn(1'b1, 8'h10, 32'h0, 1'b0, 32'h12345678, 1'b0, 7);
    join
    @(negedge clk);

    // CPU writes on both sides of the protect boundary.
    wren_cnt = 0;
`ifdef MEM_ARB_WRITE_PROTECT_EN
    txn(1'b0, 8'h3F, 32'hCAFE003F, 1'b1, 32'hA5A50011, 1'b1, 3);
    chk("prot_write_no_pulse", 32'(wren_cnt), 32'd0);
    chk("prot_write_mem", mem[8'h3F], 32'h1111003F);
`else
    txn(1'b0, 8'h3F, 32'hCAFE003F, 1'b1, 32'hA5A50011, 1'b0, 3);
    chk("write_3f_pulse", 32'(wren_cnt), 32'd1);
    chk("write_3f_mem", mem[8'h3F], 32'hCAFE003F);
`endif
    @(negedge clk);
    wren_cnt = 0;
    txn(1'b0, 8'h40, 32'hBEEF0040, 1'b1, 32'hA5A50011, 1'b0, 3);
    chk("write_40_pulse", 32'(wren_cnt), 32'd1);
    chk("write_40_mem", mem[8'h40], 32'hBEEF0040);
    @(negedge clk);

    // Loader holds req for three back-to-back reads.
    txn(1'b1, 8'h05, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 3);
    snap = busy_low_cnt;
    ldr_req = 1'b1;
    txn(1'b1, 8'h10, 32'h0, 1'b0, 32'h12345678, 1'b0, 4);
    ldr_req = 1'b1;
    txn(1'b1, 8'h11, 32'h0, 1'b0, 32'hA5A50011, 1'b0, 4);
    chk("b2b_idle_gaps", 32'(busy_low_cnt - snap), 32'd2);
    chk("cpu_rdata_untouched", cpu_rdata, 32'hA5A50011);

    repeat (4) @(negedge clk);
    chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    chk("ldr_queue_drained", 32'(ldr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
